mac_accumulator_8bit: RTL and testbench

//  Downstream consumer of the 8-bit gate-level multiplier's product.

---
 rtl/mac_accumulator_8bit.sv | 161 ++++++++++++++++
 tb/tb_mac_accumulator_8bit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator_8bit.sv
// -----------------------------------------------------------------------------
// mac_accumulator_8bit
//
// Multiply-accumulate back end for the 8-bit multiplier. After an accepted
// start it sums `len` unsigned 8-bit product terms into an ACC_W-bit
// accumulator. The products arrive on a valid/ready handshake, and the result
// is returned on a second valid/ready handshake.
//
// Parameters
//   ACC_W      accumulator / result width, must be >= 9 (default 16)
//   LEN_W      width of the term-count input (default 8)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   start      begin a new sequence (honoured only while idle)
//   len        number of product terms, sampled with an accepted start
//   prod       unsigned product term
//   prod_valid prod is valid this cycle
//   prod_ready block accepts prod this cycle (high only while accumulating)
//   res        accumulated sum
//   res_valid  res is valid; held until res_ready
//   res_ready  consumer accepts res
//   busy       sequence in progress (accumulating or holding a result)
//   overflow   sticky per sequence: a carry out of bit ACC_W-1 occurred
//
// Build option
//   MAC_SATURATE_EN  when defined, the accumulator clamps to all-ones on a
//                    carry instead of wrapping modulo 2^ACC_W. Handshake
//                    timing and latency are the same in both builds.
// -----------------------------------------------------------------------------
module mac_accumulator_8bit #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_next;
    logic             ovf;
    logic             ovf_next;
    logic             prod_ready_next;
    logic             res_valid_next;
    logic             busy_next;

    logic             xfer;
    logic [SUM_W-1:0] sum;
    logic [ACC_W-1:0] sum_acc;

    // One extra bit on the adder exposes the carry out of the accumulator.
    assign sum = {1'b0, acc} + SUM_W'(prod);

    // Value the accumulator takes on a transfer in this build.
`ifdef MAC_SATURATE_EN
    // Once clamped the accumulator stays all-ones: any non-zero term carries
    // again and a zero term leaves it unchanged.
    assign sum_acc = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign sum_acc = sum[ACC_W-1:0];
`endif

    // prod_ready is the registered "in ACCUM" flag, so this is the handshake.
    assign xfer = prod_valid && prod_ready;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    acc_next = '0;
                    ovf_next = 1'b0;
                    if (len != '0) begin
                        cnt_next   = len;
                        state_next = S_ACCUM;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end

            S_ACCUM: begin
                if (xfer) begin
                    acc_next = sum_acc;
                    ovf_next = ovf | sum[ACC_W];
                    cnt_next = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (res_valid && res_ready) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        prod_ready_next = (state_next == S_ACCUM);
        res_valid_next  = (state_next == S_DONE);
        busy_next       = (state_next != S_IDLE);
    end

    // State, datapath and output flags; reset discards any partial sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            prod_ready <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            ovf        <= ovf_next;
            prod_ready <= prod_ready_next;
            res_valid  <= res_valid_next;
            busy       <= busy_next;
        end
    end

    // The result and the sticky flag are the accumulator registers themselves,
    // so they hold their last values through DONE and the following IDLE.
    assign res      = acc;
    assign overflow = ovf;

endmodule

// File: tb/tb_mac_accumulator_8bit.sv
// -----------------------------------------------------------------------------
// tb_mac_accumulator_8bit
//
// The bench runs a narrow (ACC_W=9) instance so that the accumulator wraps or
// saturates often. The reference model tracks only the sequence phase, the
// terms still owed and the exact unbounded sum of the accepted products. The
// expected res and overflow values are derived from that sum.
// -----------------------------------------------------------------------------
module tb_mac_accumulator_8bit;

    localparam int unsigned ACC_W = 9;
    localparam int unsigned LEN_W = 8;
    localparam longint      LIMIT = longint'(1) << ACC_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [7:0]       prod = '0;
    logic             prod_valid = 1'b0;
    logic             prod_ready;
    logic [ACC_W-1:0] res;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             busy;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    mac_accumulator_8bit #(
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .prod      (prod),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 collecting terms, 2 result offered.
    int     m_phase = 0;
    int     m_rem   = 0;
    longint m_sum   = 0;
    bit     m_live  = 1'b0;

    function automatic logic [ACC_W-1:0] exp_res(input longint s);
`ifdef MAC_SATURATE_EN
        if (s >= LIMIT) return {ACC_W{1'b1}};
        return ACC_W'(s);
`else
        return ACC_W'(s % LIMIT);
`endif
    endfunction

    function automatic logic exp_ovf(input longint s);
        return s >= LIMIT;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_sum   = 0;
            m_rem   = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_sum = 0;
                    if (len == '0) m_phase = 2;
                    else begin
                        m_phase = 1;
                        m_rem   = int'(len);
                    end
                end
                1: if (prod_valid) begin
                    m_sum += longint'(prod);
                    m_rem--;
                    if (m_rem == 0) m_phase = 2;
                end
                2: if (res_ready) m_phase = 0;
                default: ;
            endcase
        end
        m_live = 1'b1;
    end

    // Cycle-by-cycle compare on the falling edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("prod_ready", 64'(prod_ready), 64'(m_phase == 1));
            chk("res_valid", 64'(res_valid), 64'(m_phase == 2));
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("overflow", 64'(overflow), 64'(exp_ovf(m_sum)));
            if (m_phase != 1) chk("res", 64'(res), 64'(exp_res(m_sum)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_seq(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int v);
        prod_valid = 1'b1;
        prod       = 8'(v);
        step();
        prod_valid = 1'b0;
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        step();
    endtask

    // Random sequence: random valid gaps, stray starts, and a random result hold.
    task automatic run_rand(input int n, input int vpct, input int pmax, input int hold);
        int guard;
        begin_seq(n);
        guard = 0;
        while (m_phase != 2 && guard < 2000) begin
            prod_valid = ($urandom_range(99) < vpct);
            prod       = 8'($urandom_range(pmax));
            start      = ($urandom_range(9) == 0);
            len        = LEN_W'($urandom_range(255));
            step();
            guard++;
        end
        prod_valid = 1'b0;
        start      = 1'b0;
        if (guard >= 2000) chk("rand_timeout", 64'(guard), 64'(0));
        for (int i = 0; i < hold; i++) begin
            start = 1'($urandom_range(1));
            step();
        end
        start = 1'b0;
        accept_result();
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of a sequence.
        begin_seq(5);
        feed(100);
        feed(50);
        rst_n = 1'b0;
        step();
        step();
        chk("rst_res", 64'(res), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_prod_ready", 64'(prod_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        step();

        // Three back-to-back terms.
        begin_seq(3);
        prod_valid = 1'b1;
        prod = 8'd10; step();
        prod = 8'd20; step();
        prod = 8'd30; step();
        prod_valid = 1'b0;
        chk("t2_res_valid", 64'(res_valid), 64'(1));
        chk("t2_res", 64'(res), 64'(60));
        chk("t2_overflow", 64'(overflow), 64'(0));
        accept_result();

        // Zero-length sequence.
        begin_seq(0);
        chk("t3_res_valid", 64'(res_valid), 64'(1));
        chk("t3_res", 64'(res), 64'(0));
        chk("t3_prod_ready", 64'(prod_ready), 64'(0));
        accept_result();

        // Gapped valid: 1,0,1,0,1,0,1 carrying 1,2,3,4.
        begin_seq(4);
        for (int i = 0; i < 7; i++) begin
            prod_valid = ((i % 2) == 0);
            prod       = (i % 2 == 0) ? 8'(i / 2 + 1) : 8'hEE;
            step();
        end
        prod_valid = 1'b0;
        chk("t4_res_valid", 64'(res_valid), 64'(1));
        chk("t4_res", 64'(res), 64'(10));

        // Result held with start pulses while waiting.
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            len   = 8'd7;
            step();
            chk("t5_res_hold", 64'(res), 64'(10));
            chk("t5_busy_hold", 64'(busy), 64'(1));
        end
        start = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("t5_idle_busy", 64'(busy), 64'(0));
        chk("t5_idle_res", 64'(res), 64'(10));
        step();

        // Carry out of a 9-bit accumulator.
        begin_seq(3);
        feed(255);
        feed(255);
        feed(255);
`ifdef MAC_SATURATE_EN
        chk("t6_res", 64'(res), 64'(511));
`else
        chk("t6_res", 64'(res), 64'(253));
`endif
        chk("t6_overflow", 64'(overflow), 64'(1));
        accept_result();
        chk("t6_idle_overflow", 64'(overflow), 64'(1));

        // The next accepted start clears the overflow flag.
        begin_seq(1);
        feed(7);
        chk("t6_ovf_cleared", 64'(overflow), 64'(0));
        chk("t6_small_res", 64'(res), 64'(7));
        accept_result();

        // Randomized sequences, small and large terms.
        for (int k = 0; k < 40; k++) begin
            run_rand($urandom_range(12), 30 + $urandom_range(70),
                     (k % 2 == 0) ? 20 : 255, $urandom_range(4));
        end

        // Maximum length with tiny terms.
        run_rand(255, 80, 1, 2);

        // Random reset in the middle of a random sequence.
        begin_seq(9);
        for (int i = 0; i < 4; i++) feed($urandom_range(255));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rst2_busy", 64'(busy), 64'(0));
        chk("rst2_res", 64'(res), 64'(0));
        run_rand(6, 60, 255, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
